// File: rtl/circular_fifo_core.sv
// Circular-buffer FIFO storage engine: wrap-bit pointers, show-ahead read data,
// watermarks, sticky overflow/underflow flags and a synchronous flush.
module circular_fifo_core #(
    parameter int unsigned WIDTH               = 8,
    parameter int unsigned POINTER_WIDTH       = 4,
    parameter int unsigned ALMOST_FULL_THRESH  = 12,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         fifo_input_data,
    input  logic                     flush,
    input  logic                     err_clear,
    output logic [WIDTH-1:0]         fifo_output_data,
    output logic                     full,
    output logic                     empty,
    output logic [POINTER_WIDTH:0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DEPTH = 2 ** POINTER_WIDTH;
    localparam int unsigned PTR_W = POINTER_WIDTH + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;

    logic [PTR_W-1:0] w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic             w_wr_reject;
    logic             w_rd_reject;

    // Status is a pure function of the pointer registers.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[POINTER_WIDTH] != r_rd_ptr[POINTER_WIDTH]) &&
                     (r_wr_ptr[POINTER_WIDTH-1:0] == r_rd_ptr[POINTER_WIDTH-1:0]);

    // A pop on a full FIFO frees the slot that the simultaneous push reuses.
    assign w_wr_accept = !flush && wr_en && (!w_full || rd_en);
    assign w_rd_accept = !flush && rd_en && !w_empty;
    assign w_wr_reject = !flush && wr_en && w_full && !rd_en;
    assign w_rd_reject = !flush && rd_en && w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[POINTER_WIDTH-1:0]] <= fifo_input_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !err_clear) || w_wr_reject;
            r_underflow <= (r_underflow && !err_clear) || w_rd_reject;
        end
    end

    assign fifo_output_data = w_empty ? '0 : r_mem[r_rd_ptr[POINTER_WIDTH-1:0]];
    assign full             = w_full;
    assign empty            = w_empty;
    assign count            = w_count;
    assign almost_full      = (w_count >= PTR_W'(ALMOST_FULL_THRESH));
    assign almost_empty     = (w_count <= PTR_W'(ALMOST_EMPTY_THRESH));
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;

endmodule
